// File: rtl/clefia_arbiter.sv
// rtl/clefia_arbiter.sv - two-port round-robin arbiter and KEYSET/DATASET sequencer for one CLEFIA core
//
// Grants the core to one of two requesters. It reloads the key only when the
// expanded key context is missing, belongs to the other requester, or uses a
// different key length. It returns the result with a one-cycle DONE pulse and
// aborts hung wait states with a one-cycle ERR pulse.
//
// Ports:
//   CLK, SRST                 clock, synchronous active-high reset
//   REQ[1:0]                  request levels, held until DONE/ERR
//   MODE0/1, ENCDEC0/1        per-requester key length / direction
//   KEY0/1, DIN0/1            per-requester key (right-aligned) / data block
//   KEYCHG[1:0]               pulse: requester i changed its key
//   DONE[1:0], ERR[1:0]       completion / timeout pulses, indexed by requester
//   RDOUT                     result, held until next capture
//   C_MODE..C_DIN             drive the core inputs
//   C_BSY, C_DVLD, C_DOUT     core status and result
module clefia_arbiter #(
    parameter int TMO_W = 10
) (
    input  logic         CLK,
    input  logic         SRST,
    input  logic [1:0]   REQ,
    input  logic [1:0]   MODE0,
    input  logic [1:0]   MODE1,
    input  logic         ENCDEC0,
    input  logic         ENCDEC1,
    input  logic [255:0] KEY0,
    input  logic [255:0] KEY1,
    input  logic [127:0] DIN0,
    input  logic [127:0] DIN1,
    input  logic [1:0]   KEYCHG,
    output logic [1:0]   DONE,
    output logic [1:0]   ERR,
    output logic [127:0] RDOUT,
    output logic [1:0]   C_MODE,
    output logic         C_ENCDEC,
    output logic         C_KEYSET,
    output logic         C_DATASET,
    output logic [255:0] C_KEY,
    output logic [127:0] C_DIN,
    input  logic         C_BSY,
    input  logic         C_DVLD,
    input  logic [127:0] C_DOUT
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_KSET  = 3'd1;
    localparam logic [2:0] S_KBSY  = 3'd2;
    localparam logic [2:0] S_KWAIT = 3'd3;
    localparam logic [2:0] S_DSET  = 3'd4;
    localparam logic [2:0] S_DBSY  = 3'd5;
    localparam logic [2:0] S_DWAIT = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]       state, nstate;
    logic             kvalid, owner, last, grant, kchg_pend;
    logic [1:0]       lmode;
    logic [TMO_W-1:0] cnt, cnt_inc;

    logic             gnt_sel, reload, in_wait, tmo, tmo_hit, grant_now, kwait_exit;
    logic [1:0]       sel_mode;

    // Contention goes to whoever was not served last.
    assign gnt_sel  = (REQ == 2'b11) ? ~last : REQ[1];
    assign sel_mode = gnt_sel ? MODE1 : MODE0;

    // A key change arriving on the grant edge already invalidates the context.
    assign reload   = !(kvalid && !KEYCHG[owner]) || (owner != gnt_sel) || (lmode != sel_mode);

    assign in_wait  = (state == S_KBSY) || (state == S_KWAIT) ||
                      (state == S_DBSY) || (state == S_DWAIT);
    assign cnt_inc  = cnt + 1'b1;
    assign tmo      = &cnt_inc;

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (REQ != 2'b00) nstate = reload ? S_KSET : S_DSET;
            S_KSET:  nstate = S_KBSY;
            S_KBSY:  if (C_BSY)       nstate = S_KWAIT;
                     else if (tmo)    nstate = S_IDLE;
            S_KWAIT: if (!C_BSY)      nstate = S_DSET;
                     else if (tmo)    nstate = S_IDLE;
            S_DSET:  nstate = S_DBSY;
            S_DBSY:  if (C_BSY)       nstate = S_DWAIT;
                     else if (tmo)    nstate = S_IDLE;
            S_DWAIT: if (C_DVLD)      nstate = S_DONE;
                     else if (tmo)    nstate = S_IDLE;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // The only way from a wait state back to IDLE is the timeout.
    assign tmo_hit    = in_wait && (nstate == S_IDLE);
    assign grant_now  = (state == S_IDLE) && (REQ != 2'b00);
    assign kwait_exit = (state == S_KWAIT) && (nstate == S_DSET);

    always_ff @(posedge CLK) begin
        if (SRST) begin
            state     <= S_IDLE;
            kvalid    <= 1'b0;
            owner     <= 1'b0;
            lmode     <= 2'b00;
            last      <= 1'b1;
            grant     <= 1'b0;
            kchg_pend <= 1'b0;
            cnt       <= '0;
            DONE      <= 2'b00;
            ERR       <= 2'b00;
            RDOUT     <= '0;
            C_MODE    <= 2'b00;
            C_ENCDEC  <= 1'b0;
            C_KEYSET  <= 1'b0;
            C_DATASET <= 1'b0;
            C_KEY     <= '0;
            C_DIN     <= '0;
        end else begin
            state     <= nstate;
            C_KEYSET  <= (nstate == S_KSET);
            C_DATASET <= (nstate == S_DSET);
            DONE      <= (nstate == S_DONE) ? {grant, ~grant} : 2'b00;
            ERR       <= tmo_hit ? {grant, ~grant} : 2'b00;

            if (nstate != state)
                cnt <= '0;
            else if (in_wait)
                cnt <= cnt_inc;

            if (grant_now) begin
                grant     <= gnt_sel;
                last      <= gnt_sel;
                C_MODE    <= sel_mode;
                C_ENCDEC  <= gnt_sel ? ENCDEC1 : ENCDEC0;
                C_KEY     <= gnt_sel ? KEY1 : KEY0;
                C_DIN     <= gnt_sel ? DIN1 : DIN0;
                kchg_pend <= 1'b0;
            end else if (((state == S_KSET) || (state == S_KBSY) || (state == S_KWAIT)) &&
                         KEYCHG[grant]) begin
                kchg_pend <= 1'b1;
            end

            if (kvalid && KEYCHG[owner])
                kvalid <= 1'b0;

            // A key change seen anywhere during the load, including this edge,
            // leaves the freshly loaded context marked invalid.
            if (kwait_exit) begin
                owner  <= grant;
                lmode  <= C_MODE;
                kvalid <= !(kchg_pend || KEYCHG[grant]);
            end

            if (tmo_hit)
                kvalid <= 1'b0;

            if ((state == S_DWAIT) && C_DVLD)
                RDOUT <= C_DOUT;
        end
    end

endmodule

// File: doc/clefia_arbiter.md
# clefia_arbiter

Two-port request arbiter and sequencer placed in front of the single CLEFIA core. It grants the core to one of two requesters round-robin and tracks which requester's key is currently expanded. It issues a KEYSET sequence only when the loaded key context is missing or belongs to someone else, then runs the DATASET sequence. It returns the 128-bit result to the granted requester with a one-cycle DONE pulse, and aborts hung operations with a timeout.

## Interface
Parameters:
- TMO_W, 10: wait-counter width; a wait state aborts when the counter reaches all-ones (1023 cycles).

Ports:
- CLK  in  1  system clock
- SRST  in  1  synchronous reset, active-high
- REQ  in  2  per-requester request level; held high, with operands stable, until DONE/ERR for that requester
- MODE0, MODE1  in  2 each  key length: 00 = 128, 01 = 192, 10 = 256
- ENCDEC0, ENCDEC1  in  1 each  0 = encrypt, 1 = decrypt
- KEY0, KEY1  in  256 each  requester key, right-aligned
- DIN0, DIN1  in  128 each  requester data block
- KEYCHG  in  2  one-cycle pulse: requester i changed its key
- DONE  out  2  one-cycle completion pulse, indexed by requester
- ERR  out  2  one-cycle timeout pulse, indexed by requester
- RDOUT  out  128  result; valid in the DONE cycle, held until the next capture
- C_MODE, C_ENCDEC, C_KEYSET, C_DATASET, C_KEY, C_DIN  out  2/1/1/1/256/128  drive the core's MODE, ENCDEC, KEYSET, DATASET, KEY, DIN
- C_BSY, C_DVLD, C_DOUT  in  1/1/128  core's BSY, DVLD, DOUT

## Operation
- All outputs are registered. Reset values:
  - every output 0, including C_MODE = 00 and RDOUT = 0;
  - state IDLE, KVALID = 0, OWNER = 0, LMODE = 00, LAST = 1, counter = 0.
- SRST at any time, including mid-operation, forces these reset values on the next edge. No DONE or ERR is emitted for the aborted request.
- Arbitration happens in IDLE only:
  - one REQ bit set: grant that requester;
  - both set: grant the requester ≠ LAST;
  - on grant, LAST ← grant.
- On grant, latch the requester's MODE, ENCDEC, KEY and DIN into C_MODE, C_ENCDEC, C_KEY, C_DIN. These stay constant until the state returns to IDLE.
- Reload condition: !KVALID, or OWNER ≠ grant, or LMODE ≠ granted MODE.
  - Reload true: go to KSET.
  - Reload false: go to DSET.
- State sequence:
  - KSET: C_KEYSET = 1 for exactly one cycle; then KBSY.
  - KBSY: wait for C_BSY = 1; then KWAIT.
  - KWAIT: wait for C_BSY = 0; then set KVALID = 1, OWNER = grant, LMODE = mode; go to DSET.
  - DSET: C_DATASET = 1 for exactly one cycle; then DBSY.
  - DBSY: wait for C_BSY = 1; then DWAIT.
  - DWAIT: wait for C_DVLD = 1; capture C_DOUT into RDOUT; then DONE.
  - DONE: pulse DONE[grant] for one cycle; then IDLE.
- Timeout: the counter clears on entry to each wait state (KBSY, KWAIT, DBSY, DWAIT) and increments every cycle spent there. On reaching all-ones:
  - pulse ERR[grant];
  - clear KVALID;
  - return to IDLE;
  - leave RDOUT unchanged.
- KEYCHG[i] clears KVALID when OWNER = i and KVALID = 1.
  - During KSET..KWAIT with grant = i: the pending KWAIT validation is suppressed, so KVALID ends the operation at 0. The current data operation still completes.
  - If KEYCHG[i] coincides with the KWAIT exit edge, KEYCHG wins (KVALID = 0).
- REQ edges outside IDLE are ignored. A requester must keep REQ low for at least one cycle after its DONE/ERR before requesting again. A still-high REQ in IDLE is treated as a new request.

## Timing
- REQ sampled high in IDLE at edge t:
  - reload case: C_KEYSET = 1 during cycle t+1;
  - no-reload case: C_DATASET = 1 during cycle t+1.
- KWAIT exit at edge k: C_DATASET = 1 during cycle k+1.
- C_DVLD sampled high at edge d: RDOUT updated and DONE[grant] high during cycle d+1. Back in IDLE at d+2, so a new grant can be made at edge d+2.
- Controller overhead per operation, excluding core busy time:
  - 3 cycles without a key load;
  - +2 cycles with a key load.
- DONE and ERR are mutually exclusive and never both bits high at once.

## Test plan
- Requester 0, MODE0 = 00, KEY0 = ffeeddccbbaa99887766554433221100, DIN0 = 000102030405060708090a0b0c0d0e0f, ENCDEC0 = 0 -> exactly one KEYSET pulse, then one DATASET pulse; DONE = 01; RDOUT = de2bf2fd9b74aacdf1298555459494fd.
- Repeat the same request -> no KEYSET pulse; same RDOUT. Then ENCDEC0 = 1, DIN0 = de2bf2fd9b74aacdf1298555459494fd -> RDOUT = 000102030405060708090a0b0c0d0e0f, no KEYSET.
- REQ = 11 raised in the same cycle after reset -> requester 0 served first, then requester 1. Each grant includes a KEYSET because OWNER changes. DONE order 01, then 10.
- KEYCHG[0] pulse while idle with OWNER = 0 -> next requester-0 request issues KEYSET. MODE0 changed 00→01 -> KEYSET issued as well.
- C_BSY never rises after DATASET -> ERR[grant] high exactly 1023 cycles after entry to DBSY; no DONE; KVALID = 0, so the next request starts with KEYSET.
- SRST asserted in DWAIT -> all outputs 0 next cycle, no DONE or ERR; the following request reloads the key and gets LAST = 1 priority (requester 0 first).
